// File: rtl/ps2_mouse_init_sequencer.sv
// PS/2 mouse init sequencer and stream-mode packet assembler.
// The sequencer resets the mouse, waits for its self-test and ID bytes, enables
// data reporting, then assembles 3-byte movement packets.
// Optional feature macro: PS2_MOUSE_RATE_SET_EN adds a sample-rate command
// (0xF3, SAMPLE_RATE) after data reporting is enabled.
module ps2_mouse_init_sequencer #(
    parameter int unsigned TIMEOUT_CYCLES = 50000000,
    parameter int unsigned MAX_RETRIES    = 3
`ifdef PS2_MOUSE_RATE_SET_EN
    ,
    parameter logic [7:0]  SAMPLE_RATE    = 8'd100
`endif
) (
    input  logic       Clk,
    input  logic       Reset,
    output logic [7:0] TxData,
    output logic       TxStart,
    input  logic       TxBusy,
    input  logic       TxDone,
    input  logic       TxError,
    input  logic [7:0] RxData,
    input  logic       RxValid,
    input  logic       RxError,
    output logic [2:0] Buttons,
    output logic [8:0] DeltaX,
    output logic [8:0] DeltaY,
    output logic       PacketValid,
    output logic       Ready,
    output logic       InitError
);

    localparam int TW = $clog2(TIMEOUT_CYCLES + 1);
    localparam int RW = $clog2(MAX_RETRIES + 1);

    typedef enum logic [3:0] {
        ST_RST_SEND,
        ST_RST_ACK,
        ST_BAT,
        ST_ID,
        ST_EN_SEND,
        ST_EN_ACK,
        ST_STREAM,
        ST_ERROR
`ifdef PS2_MOUSE_RATE_SET_EN
        ,
        ST_RATE_CMD_SEND,
        ST_RATE_CMD_ACK,
        ST_RATE_VAL_SEND,
        ST_RATE_VAL_ACK
`endif
    } state_e;

    state_e        state_q, state_d;
    logic          sent_q, sent_d;       // TxStart already issued in this SEND state
    logic [TW-1:0] tmo_q, tmo_d;
    logic [RW-1:0] retry_q, retry_d;
    logic [7:0]    tx_data_q, tx_data_d;
    logic          tx_start_q, tx_start_d;
    logic [1:0]    idx_q, idx_d;
    logic [7:0]    hdr_q, hdr_d;         // latched byte 0 (buttons, signs, overflows)
    logic [7:0]    xbyte_q, xbyte_d;
    logic [2:0]    buttons_q, buttons_d;
    logic [8:0]    dx_q, dx_d;
    logic [8:0]    dy_q, dy_d;
    logic          pv_q, pv_d;

    logic          is_send, is_wait, advance, fail, tmo_hit, gap_expire;
    logic [7:0]    cmd, expect_byte;
    state_e        next_ok;

    assign tmo_hit    = (tmo_q == TW'(TIMEOUT_CYCLES - 1));
    assign gap_expire = (state_q == ST_STREAM) && (idx_q != 2'd0) && !RxValid && !RxError && tmo_hit;

    // Register all state and outputs; synchronous reset clears everything.
    always_ff @(posedge Clk) begin
        // NOTE: sequential state uses non-blocking assignments so every register
        // samples the pre-edge values regardless of statement order.
        if (Reset) begin
            state_q    <= ST_RST_SEND;
            sent_q     <= 1'b0;
            tmo_q      <= '0;
            retry_q    <= '0;
            tx_data_q  <= 8'h00;
            tx_start_q <= 1'b0;
            idx_q      <= 2'd0;
            hdr_q      <= 8'h00;
            xbyte_q    <= 8'h00;
            buttons_q  <= 3'b000;
            dx_q       <= 9'h000;
            dy_q       <= 9'h000;
            pv_q       <= 1'b0;
        end else begin
            state_q    <= state_d;
            sent_q     <= sent_d;
            tmo_q      <= tmo_d;
            retry_q    <= retry_d;
            tx_data_q  <= tx_data_d;
            tx_start_q <= tx_start_d;
            idx_q      <= idx_d;
            hdr_q      <= hdr_d;
            xbyte_q    <= xbyte_d;
            buttons_q  <= buttons_d;
            dx_q       <= dx_d;
            dy_q       <= dy_d;
            pv_q       <= pv_d;
        end
    end

    // Init sequencer: command issue, response matching, timeout and retry policy.
    always_comb begin
        // NOTE: every variable gets a default first so no path can infer a latch.
        state_d     = state_q;
        sent_d      = sent_q;
        tmo_d       = tmo_q;
        retry_d     = retry_q;
        tx_data_d   = tx_data_q;
        tx_start_d  = 1'b0;
        is_send     = 1'b0;
        is_wait     = 1'b0;
        cmd         = 8'h00;
        expect_byte = 8'h00;
        next_ok     = state_q;
        advance     = 1'b0;
        fail        = 1'b0;

        case (state_q)
            ST_RST_SEND: begin is_send = 1'b1; cmd = 8'hFF;         next_ok = ST_RST_ACK; end
            ST_RST_ACK:  begin is_wait = 1'b1; expect_byte = 8'hFA; next_ok = ST_BAT;     end
            ST_BAT:      begin is_wait = 1'b1; expect_byte = 8'hAA; next_ok = ST_ID;      end
            ST_ID:       begin is_wait = 1'b1; expect_byte = 8'h00; next_ok = ST_EN_SEND; end
            ST_EN_SEND:  begin is_send = 1'b1; cmd = 8'hF4;         next_ok = ST_EN_ACK;  end
            ST_EN_ACK: begin
                is_wait     = 1'b1;
                expect_byte = 8'hFA;
`ifdef PS2_MOUSE_RATE_SET_EN
                next_ok     = ST_RATE_CMD_SEND;
`else
                next_ok     = ST_STREAM;
`endif
            end
`ifdef PS2_MOUSE_RATE_SET_EN
            ST_RATE_CMD_SEND: begin is_send = 1'b1; cmd = 8'hF3;         next_ok = ST_RATE_CMD_ACK;  end
            ST_RATE_CMD_ACK:  begin is_wait = 1'b1; expect_byte = 8'hFA; next_ok = ST_RATE_VAL_SEND; end
            ST_RATE_VAL_SEND: begin is_send = 1'b1; cmd = SAMPLE_RATE;   next_ok = ST_RATE_VAL_ACK;  end
            ST_RATE_VAL_ACK:  begin is_wait = 1'b1; expect_byte = 8'hFA; next_ok = ST_STREAM;        end
`endif
            ST_STREAM: begin
                // Reused as the inter-byte gap timer while a packet is partial.
                if (RxValid || RxError || idx_q == 2'd0 || tmo_hit) tmo_d = '0;
                else                                                 tmo_d = tmo_q + 1'b1;
            end
            default: ;
        endcase

        if (is_send) begin
            // Receive-side traffic here is stale (e.g. from before a reset) and ignored.
            if (sent_q && TxDone)       advance = 1'b1;
            else if (sent_q && TxError) fail    = 1'b1;
            else if (tmo_hit)           fail    = 1'b1;
            else begin
                tmo_d = tmo_q + 1'b1;
                if (!sent_q && !TxBusy) begin
                    tx_start_d = 1'b1;
                    tx_data_d  = cmd;
                    sent_d     = 1'b1;
                end
            end
        end else if (is_wait) begin
            if (RxError)      fail = 1'b1;
            else if (RxValid) begin
                if (RxData == expect_byte) advance = 1'b1;
                else                       fail    = 1'b1;
            end
            else if (tmo_hit) fail = 1'b1;
            else              tmo_d = tmo_q + 1'b1;
        end

        if (advance) begin
            state_d = next_ok;
            tmo_d   = '0;
            sent_d  = 1'b0;
        end else if (fail) begin
            tmo_d  = '0;
            sent_d = 1'b0;
            if (retry_q < RW'(MAX_RETRIES - 1)) begin
                retry_d = retry_q + 1'b1;
                state_d = ST_RST_SEND;
            end else begin
                state_d = ST_ERROR;
            end
        end
    end

    // Stream-mode packet assembly with header resync and gap/error discard.
    always_comb begin
        idx_d     = idx_q;
        hdr_d     = hdr_q;
        xbyte_d   = xbyte_q;
        buttons_d = buttons_q;
        dx_d      = dx_q;
        dy_d      = dy_q;
        pv_d      = 1'b0;

        if (state_q == ST_STREAM) begin
            if (RxError) begin
                idx_d = 2'd0;
            end else if (RxValid) begin
                case (idx_q)
                    2'd0: begin
                        // Bit 3 is always set in a header byte; anything else is a misaligned byte.
                        if (RxData[3]) begin
                            hdr_d = RxData;
                            idx_d = 2'd1;
                        end
                    end
                    2'd1: begin
                        xbyte_d = RxData;
                        idx_d   = 2'd2;
                    end
                    default: begin
                        buttons_d = hdr_q[2:0];
                        dx_d      = hdr_q[6] ? 9'h000 : {hdr_q[4], xbyte_q};
                        dy_d      = hdr_q[7] ? 9'h000 : {hdr_q[5], RxData};
                        pv_d      = 1'b1;
                        idx_d     = 2'd0;
                    end
                endcase
            end else if (gap_expire) begin
                idx_d = 2'd0;
            end
        end
    end

    assign TxData      = tx_data_q;
    assign TxStart     = tx_start_q;
    assign Buttons     = buttons_q;
    assign DeltaX      = dx_q;
    assign DeltaY      = dy_q;
    assign PacketValid = pv_q;
    assign Ready       = (state_q == ST_STREAM);
    assign InitError   = (state_q == ST_ERROR);

endmodule

// File: tb/tb_ps2_mouse_init_sequencer.sv
// Self-checking bench for ps2_mouse_init_sequencer: a transceiver responder,
// directed init/retry/failure scenarios and randomized stream packets checked
// against a packet-decoding reference function.
module tb_ps2_mouse_init_sequencer;

    localparam int TMO = 1000;

    logic       Clk, Reset;
    logic [7:0] TxData;
    logic       TxStart, TxBusy, TxDone, TxError;
    logic [7:0] RxData;
    logic       RxValid, RxError;
    logic [2:0] Buttons;
    logic [8:0] DeltaX, DeltaY;
    logic       PacketValid, Ready, InitError;

    ps2_mouse_init_sequencer #(.TIMEOUT_CYCLES(TMO)) dut (
        .Clk(Clk), .Reset(Reset),
        .TxData(TxData), .TxStart(TxStart), .TxBusy(TxBusy), .TxDone(TxDone), .TxError(TxError),
        .RxData(RxData), .RxValid(RxValid), .RxError(RxError),
        .Buttons(Buttons), .DeltaX(DeltaX), .DeltaY(DeltaY),
        .PacketValid(PacketValid), .Ready(Ready), .InitError(InitError)
    );

    int         checks = 0;
    int         errors = 0;
    int         cyc = 0;
    int         done_cnt = 0;
    int         tx_count = 0;
    int         pv_cnt = 0;
    logic [7:0] sent_log[$];
    int         sent_cyc[$];

    initial begin
        Clk = 1'b0;
        forever #5 Clk = ~Clk;
    end

    always @(posedge Clk) cyc <= cyc + 1;

    always @(negedge Clk) if (PacketValid === 1'b1) pv_cnt++;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Reference decode of one stream packet, straight from the field definitions.
    function automatic int exp_delta(input int hdr, input int sign_bit, input int ov_bit, input int mag);
        if (((hdr >> ov_bit) & 1) != 0) return 0;
        if (((hdr >> sign_bit) & 1) != 0) return mag - 256;
        return mag;
    endfunction

    // Transceiver model: captures each command, stays busy a random time, then acks.
    initial begin
        logic [7:0] cap;
        TxBusy  = 1'b0;
        TxDone  = 1'b0;
        TxError = 1'b0;
        forever begin
            @(negedge Clk);
            if (TxStart === 1'b1) begin
                cap = TxData;
                sent_log.push_back(cap);
                sent_cyc.push_back(cyc);
                tx_count++;
                TxBusy = 1'b1;
                @(negedge Clk);
                check("txstart_one_cycle", TxStart, 0);
                repeat ($urandom_range(1, 5)) @(negedge Clk);
                check("txdata_stable", TxData, cap);
                TxBusy = 1'b0;
                TxDone = 1'b1;
                done_cnt++;
                @(negedge Clk);
                TxDone = 1'b0;
            end
        end
    end

    task automatic send_rx(input logic [7:0] b, input int idle);
        @(negedge Clk);
        RxData  = b;
        RxValid = 1'b1;
        @(negedge Clk);
        RxValid = 1'b0;
        repeat (idle) @(negedge Clk);
    endtask

    task automatic wait_done(input int n, input int limit);
        int t = 0;
        while (done_cnt < n && t < limit) begin
            @(negedge Clk);
            t++;
        end
        check("txdone_wait", (done_cnt >= n), 1);
    endtask

    task automatic do_reset();
        @(negedge Clk);
        Reset = 1'b1;
        repeat (2) @(negedge Clk);
        check("rst_txdata", TxData, 0);
        check("rst_txstart", TxStart, 0);
        check("rst_buttons", Buttons, 0);
        check("rst_dx", DeltaX, 0);
        check("rst_dy", DeltaY, 0);
        check("rst_pv", PacketValid, 0);
        check("rst_ready", Ready, 0);
        check("rst_initerr", InitError, 0);
        Reset = 1'b0;
    endtask

    // Walk the mouse through power-up, rejecting the reset n_fc times first.
    task automatic run_init(input int n_fc);
        int         n0 = done_cnt;
        int         s0 = sent_log.size();
        int         k = 0;
        logic [7:0] exp_cmds[$];
        for (int i = 0; i < n_fc; i++) begin
            wait_done(n0 + i + 1, 3000);
            send_rx(8'hFC, 1);
            exp_cmds.push_back(8'hFF);
        end
        exp_cmds.push_back(8'hFF);
        wait_done(n0 + n_fc + 1, 3000);
        send_rx(8'hFA, $urandom_range(0, 3));
        send_rx(8'hAA, $urandom_range(0, 3));
        send_rx(8'h00, $urandom_range(0, 3));
        exp_cmds.push_back(8'hF4);
        wait_done(n0 + n_fc + 2, 3000);
`ifdef PS2_MOUSE_RATE_SET_EN
        send_rx(8'hFA, 0);
        exp_cmds.push_back(8'hF3);
        wait_done(n0 + n_fc + 3, 3000);
        send_rx(8'hFA, 0);
        exp_cmds.push_back(8'h64);
        wait_done(n0 + n_fc + 4, 3000);
`endif
        check("ready_before_ack", Ready, 0);
        send_rx(8'hFA, 0);
        check("ready_after_ack", Ready, 1);
        check("initerr_clean", InitError, 0);
        check("cmd_count", sent_log.size() - s0, exp_cmds.size());
        foreach (exp_cmds[i]) begin
            k = s0 + i;
            if (k < sent_log.size()) check("cmd_byte", sent_log[k], exp_cmds[i]);
        end
    endtask

    task automatic expect_packet(input logic [7:0] b0, input logic [7:0] bx, input logic [7:0] by);
        int pv0 = pv_cnt;
        send_rx(b0, $urandom_range(0, 3));
        send_rx(bx, $urandom_range(0, 3));
        send_rx(by, 0);
        check("pkt_pv", PacketValid, 1);
        check("pkt_buttons", Buttons, int'(b0) % 8);
        check("pkt_dx", 32'($signed(DeltaX)), exp_delta(int'(b0), 4, 6, int'(bx)));
        check("pkt_dy", 32'($signed(DeltaY)), exp_delta(int'(b0), 5, 7, int'(by)));
        @(negedge Clk);
        check("pkt_pv_pulse", PacketValid, 0);
        @(negedge Clk);
        check("pkt_pv_count", pv_cnt - pv0, 1);
    endtask

    initial begin
        int n0, s0, t, txs, d;
        logic [7:0] hb;
        Reset   = 1'b1;
        RxData  = 8'h00;
        RxValid = 1'b0;
        RxError = 1'b0;

        // Clean init and the fixed packet.
        do_reset();
        run_init(0);
        expect_packet(8'h39, 8'h05, 8'hFB);
        check("pkt_fixed_dx", DeltaX, 9'h105);
        check("pkt_fixed_dy", DeltaY, 9'h1FB);

        // Resync on a non-header byte, then an X-overflow packet.
        send_rx(8'h00, 2);
        expect_packet(8'h48, 8'h7F, 8'h10);
        check("ovf_dx", DeltaX, 9'h000);
        check("ovf_dy", DeltaY, 9'h010);

        // Randomized packets, each preceded by a few misaligned bytes.
        for (int i = 0; i < 8; i++) begin
            for (int j = 0; j < int'($urandom_range(0, 2)); j++)
                send_rx(8'($urandom) & 8'hF7, $urandom_range(0, 2));
            hb = 8'($urandom) | 8'h08;
            expect_packet(hb, 8'($urandom), 8'($urandom));
        end

        // Reset in the middle of a packet, re-init, then an inter-byte gap timeout.
        send_rx(8'h08, 1);
        send_rx(8'h01, 1);
        do_reset();
        run_init(0);
        send_rx(8'h08, 0);
        send_rx(8'h01, 0);
        repeat (TMO + 10) @(negedge Clk);
        expect_packet(8'h09, 8'h02, 8'h03);
        check("gap_dx", DeltaX, 9'h002);
        check("gap_dy", DeltaY, 9'h003);

        // Two rejected resets, then success on the third attempt.
        do_reset();
        run_init(2);

        // Silent mouse: three reset attempts one timeout apart, then terminal error.
        do_reset();
        n0 = done_cnt;
        s0 = sent_log.size();
        wait_done(n0 + 3, 4000);
        t = 0;
        while (InitError !== 1'b1 && t < 2000) begin
            @(negedge Clk);
            t++;
        end
        check("fail_initerr", InitError, 1);
        check("fail_ready", Ready, 0);
        check("fail_cmd_count", sent_log.size() - s0, 3);
        for (int i = 0; i < 3; i++)
            if (s0 + i < sent_log.size()) check("fail_cmd_byte", sent_log[s0 + i], 8'hFF);
        for (int i = 1; i < 3; i++) begin
            if (s0 + i < sent_cyc.size()) begin
                d = sent_cyc[s0 + i] - sent_cyc[s0 + i - 1];
                check("fail_spacing", (d >= TMO && d <= TMO + 15), 1);
            end
        end
        txs = tx_count;
        repeat (1500) @(negedge Clk);
        check("fail_no_tx", tx_count - txs, 0);
        check("fail_initerr_hold", InitError, 1);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
